// File: rtl/gpio_cmd_router.sv
// rtl/gpio_cmd_router.sv - GPIO command decoder/router for the 2D-convolution datapath
// Optional sticky error status: define GPIO_CMD_ROUTER_ERR_EN.
module gpio_cmd_router #(
  parameter  int GPIO_D     = 32,
  parameter  int BIT_LEN    = 8,
  parameter  int M_LEN      = 3,
  parameter  int N_BANKS    = 3,
  parameter  int NB_ADDRESS = 10,
  parameter  int RAM_WIDTH  = 13,
  localparam int DATA_W     = M_LEN * BIT_LEN,
  localparam int SEL_W      = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
  localparam int ROW_W      = (M_LEN > 1) ? $clog2(M_LEN) : 1
) (
  input  logic                  i_CLK,
  input  logic                  i_reset,
  input  logic [GPIO_D-1:0]     i_gpio,
  input  logic                  i_eop,
  input  logic [RAM_WIDTH-1:0]  i_mem_rdata,
  output logic [GPIO_D-1:0]     o_gpio_rd,
  output logic [DATA_W-1:0]     o_krnl_data,
  output logic [ROW_W-1:0]      o_krnl_row,
  output logic                  o_krnl_wr,
  output logic [NB_ADDRESS-1:0] o_img_len,
  output logic [N_BANKS-1:0]    o_mem_wen,
  output logic [NB_ADDRESS-1:0] o_mem_waddr,
  output logic [RAM_WIDTH-1:0]  o_mem_wdata,
  output logic [NB_ADDRESS-1:0] o_mem_raddr,
  output logic                  o_run,
  output logic                  o_busy
);

  localparam logic [2:0] CMD_KRNL = 3'd0;
  localparam logic [2:0] CMD_SIZE = 3'd1;
  localparam logic [2:0] CMD_IMG  = 3'd2;
  localparam logic [2:0] CMD_DREQ = 3'd3;
  localparam logic [2:0] CMD_RUN  = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RD_WAIT, S_RUNNING} state_t;
  state_t state_q, state_d;

  logic [2:0]            cmd_w, cmd_q;
  logic                  valid_w, v_q, arm_q;
  logic                  edge_w, accept_w, drop_w, bank_ok_w;
  logic [SEL_W-1:0]      bank_w;
  logic [DATA_W-1:0]     data_w;
  logic [NB_ADDRESS-1:0] wcnt_q [N_BANKS];
  logic [NB_ADDRESS-1:0] wcnt_sel_w;
  logic [NB_ADDRESS-1:0] rcnt_q;
  logic [ROW_W-1:0]      row_q;
  logic                  ack_q, done_q;
  logic [DATA_W-1:0]     krnl_data_q;
  logic [ROW_W-1:0]      krnl_row_q;
  logic                  krnl_wr_q, run_q;
  logic [NB_ADDRESS-1:0] img_len_q, waddr_q, raddr_q;
  logic [N_BANKS-1:0]    wen_q;
  logic [RAM_WIDTH-1:0]  wdata_q, rd_hold_q;
  logic [2:0]            err_q;
  logic [GPIO_D-1:0]     gpio_rd_w;
  logic                  unused_w;

  assign cmd_w     = i_gpio[GPIO_D-1 -: 3];
  assign valid_w   = i_gpio[GPIO_D-4];
  assign bank_w    = i_gpio[GPIO_D-5 -: SEL_W];
  assign data_w    = i_gpio[DATA_W:1];
  assign bank_ok_w = (int'(bank_w) < N_BANKS);

  // arm_q masks the first cycle out of reset so a valid held through reset is not seen as an edge
  assign edge_w   = valid_w & ~v_q & arm_q;
  assign accept_w = edge_w & (state_q == S_IDLE);
  assign drop_w   = edge_w & (state_q != S_IDLE);
  assign unused_w = ^{i_gpio, drop_w};

  always_comb begin
    wcnt_sel_w = '0;
    for (int b = 0; b < N_BANKS; b++)
      if (int'(bank_w) == b) wcnt_sel_w = wcnt_q[b];
  end

  always_ff @(posedge i_CLK) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept_w) state_d = S_EXEC;
      S_EXEC: begin
        if (cmd_q == CMD_DREQ)     state_d = S_RD_WAIT;
        else if (cmd_q == CMD_RUN) state_d = S_RUNNING;
        else                       state_d = S_IDLE;
      end
      S_RD_WAIT: state_d = S_IDLE;
      S_RUNNING: if (i_eop) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      v_q         <= 1'b0;
      arm_q       <= 1'b0;
      cmd_q       <= '0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
      row_q       <= '0;
      rcnt_q      <= '0;
      for (int b = 0; b < N_BANKS; b++) wcnt_q[b] <= '0;
      krnl_data_q <= '0;
      krnl_row_q  <= '0;
      krnl_wr_q   <= 1'b0;
      img_len_q   <= '0;
      wen_q       <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      raddr_q     <= '0;
      run_q       <= 1'b0;
      rd_hold_q   <= '0;
    end else begin
      v_q       <= valid_w;
      arm_q     <= 1'b1;
      krnl_wr_q <= 1'b0;
      wen_q     <= '0;
      run_q     <= 1'b0;
      if (state_q == S_RD_WAIT) rd_hold_q <= i_mem_rdata;
      if (state_q == S_RUNNING && i_eop) done_q <= 1'b1;
      if (accept_w) begin
        cmd_q <= cmd_w;
        ack_q <= ~ack_q;
        case (cmd_w)
          CMD_KRNL: begin
            krnl_data_q <= data_w;
            krnl_row_q  <= row_q;
            krnl_wr_q   <= 1'b1;
            row_q       <= (row_q == ROW_W'(M_LEN - 1)) ? '0 : row_q + 1'b1;
          end
          CMD_SIZE: begin
            img_len_q <= data_w[NB_ADDRESS-1:0];
            rcnt_q    <= '0;
            row_q     <= '0;
            for (int b = 0; b < N_BANKS; b++) wcnt_q[b] <= '0;
          end
          CMD_IMG: begin
            if (bank_ok_w) begin
              for (int b = 0; b < N_BANKS; b++) begin
                if (int'(bank_w) == b) begin
                  wen_q[b]  <= 1'b1;
                  wcnt_q[b] <= wcnt_q[b] + 1'b1;
                end
              end
              waddr_q <= wcnt_sel_w;
              wdata_q <= data_w[RAM_WIDTH-1:0];
            end
          end
          CMD_DREQ: begin
            raddr_q <= rcnt_q;
            rcnt_q  <= rcnt_q + 1'b1;
          end
          CMD_RUN: begin
            run_q  <= 1'b1;
            done_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef GPIO_CMD_ROUTER_ERR_EN
  logic wrap_w, oor_w;
  assign wrap_w = accept_w && (cmd_w == CMD_IMG) && bank_ok_w && (&wcnt_sel_w);
  assign oor_w  = accept_w && (cmd_w == CMD_IMG) && !bank_ok_w;

  always_ff @(posedge i_CLK) begin
    if (i_reset)                              err_q <= 3'b000;
    else if (accept_w && cmd_w == CMD_SIZE)   err_q <= 3'b000;
    else                                      err_q <= err_q | {drop_w, wrap_w, oor_w};
  end
`else
  assign err_q = 3'b000;
`endif

  // readback passes the BRAM data straight through in RD_WAIT, then holds the captured copy
  always_comb begin
    gpio_rd_w                   = '0;
    gpio_rd_w[GPIO_D-1]         = ack_q;
    gpio_rd_w[GPIO_D-2]         = done_q;
    gpio_rd_w[GPIO_D-3]         = (state_q == S_RUNNING);
    gpio_rd_w[GPIO_D-4 -: 3]    = err_q;
    gpio_rd_w[RAM_WIDTH-1:0]    = (state_q == S_RD_WAIT) ? i_mem_rdata : rd_hold_q;
  end

  assign o_gpio_rd   = gpio_rd_w;
  assign o_krnl_data = krnl_data_q;
  assign o_krnl_row  = krnl_row_q;
  assign o_krnl_wr   = krnl_wr_q;
  assign o_img_len   = img_len_q;
  assign o_mem_wen   = wen_q;
  assign o_mem_waddr = waddr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_raddr = raddr_q;
  assign o_run       = run_q;
  assign o_busy      = (state_q == S_RUNNING);

endmodule

// File: tb/tb_gpio_cmd_router.sv
// tb/tb_gpio_cmd_router.sv - self-checking bench for gpio_cmd_router
// Honours GPIO_CMD_ROUTER_ERR_EN when choosing expected error status.
module tb_gpio_cmd_router;

`ifdef GPIO_CMD_ROUTER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gpio;
  logic        eop;
  logic [12:0] mem_rdata;

  logic [31:0] gpio_rd;   logic [23:0] krnl_data; logic [1:0] krnl_row; logic krnl_wr;
  logic [9:0]  img_len;   logic [2:0]  mem_wen;   logic [9:0] waddr;    logic [12:0] wdata;
  logic [9:0]  raddr;     logic        run;       logic busy;

  logic [31:0] s_gpio_rd; logic [23:0] s_krnl_data; logic [1:0] s_krnl_row; logic s_krnl_wr;
  logic [1:0]  s_img_len; logic [2:0]  s_mem_wen;   logic [1:0] s_waddr;    logic [12:0] s_wdata;
  logic [1:0]  s_raddr;   logic        s_run;       logic s_busy;

  always #5 clk = ~clk;

  gpio_cmd_router dut (
    .i_CLK(clk), .i_reset(rst), .i_gpio(gpio), .i_eop(eop), .i_mem_rdata(mem_rdata),
    .o_gpio_rd(gpio_rd), .o_krnl_data(krnl_data), .o_krnl_row(krnl_row), .o_krnl_wr(krnl_wr),
    .o_img_len(img_len), .o_mem_wen(mem_wen), .o_mem_waddr(waddr), .o_mem_wdata(wdata),
    .o_mem_raddr(raddr), .o_run(run), .o_busy(busy)
  );

  gpio_cmd_router #(.NB_ADDRESS(2)) dut_s (
    .i_CLK(clk), .i_reset(rst), .i_gpio(gpio), .i_eop(eop), .i_mem_rdata(mem_rdata),
    .o_gpio_rd(s_gpio_rd), .o_krnl_data(s_krnl_data), .o_krnl_row(s_krnl_row), .o_krnl_wr(s_krnl_wr),
    .o_img_len(s_img_len), .o_mem_wen(s_mem_wen), .o_mem_waddr(s_waddr), .o_mem_wdata(s_wdata),
    .o_mem_raddr(s_raddr), .o_run(s_run), .o_busy(s_busy)
  );

  logic [12:0] bram0 [1024];
  always @(posedge clk) mem_rdata <= bram0[raddr];

  int n_chk = 0;
  int n_fail = 0;

  bit          m_ack, m_done;
  int          m_row, m_rdc, m_len;
  int          m_wcnt [3];
  int          m_swcnt [3];
  logic [2:0]  m_err, m_serr;
  logic [12:0] m_hold;

  typedef struct {
    logic [2:0]  cmd;
    logic [1:0]  bank;
    logic [23:0] data;
    logic        kwr;
    logic [1:0]  row;
    logic [2:0]  wen;
    logic [9:0]  waddr;
    logic [12:0] wdata;
    logic        ack;
  } vec_t;
  vec_t tv [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] c, input logic v, input logic [1:0] b,
                                     input logic [23:0] d);
    logic [31:0] w;
    w = '0;
    w[31:29] = c;
    w[28]    = v;
    w[27:26] = b;
    w[24:1]  = d;
    return w;
  endfunction

  function automatic logic [31:0] exp_status(input logic busy_e);
    logic [31:0] w;
    w        = '0;
    w[31]    = m_ack;
    w[30]    = m_done;
    w[29]    = busy_e;
    w[28:26] = ERR_EN ? m_err : 3'b000;
    w[12:0]  = m_hold;
    return w;
  endfunction

  task automatic model_reset();
    m_ack = 0; m_done = 0; m_row = 0; m_rdc = 0; m_len = 0;
    m_err = '0; m_serr = '0; m_hold = '0;
    for (int i = 0; i < 3; i++) begin m_wcnt[i] = 0; m_swcnt[i] = 0; end
  endtask

  task automatic apply_reset();
    rst = 1'b1; gpio = '0; eop = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  // pulse valid for one cycle; returns at the negedge of the cycle after the edge cycle
  task automatic send(input logic [2:0] c, input logic [1:0] b, input logic [23:0] d);
    gpio = mk(c, 1'b1, b, d);
    @(negedge clk);
    gpio = mk(c, 1'b0, b, d);
  endtask

  task automatic do_op(input logic [2:0] c, input logic [1:0] b, input logic [23:0] d, input bit drop);
    logic       e_kwr, e_run;
    logic [2:0] e_wen, e_swen;
    int         e_row, e_waddr, e_swaddr, e_raddr;
    e_kwr = (c == 3'd0); e_run = (c == 3'd4); e_wen = '0; e_swen = '0;
    e_row = m_row; e_waddr = 0; e_swaddr = 0; e_raddr = m_rdc;
    case (c)
      3'd0: m_row = (m_row + 1) % 3;
      3'd1: begin
        m_len = int'(d[9:0]); m_row = 0; m_rdc = 0; m_err = '0; m_serr = '0;
        for (int i = 0; i < 3; i++) begin m_wcnt[i] = 0; m_swcnt[i] = 0; end
      end
      3'd2: begin
        if (b < 2'd3) begin
          e_wen = 3'b001 << b; e_swen = e_wen;
          e_waddr = m_wcnt[b]; e_swaddr = m_swcnt[b];
          if (m_wcnt[b] == 1023) m_err[1] = 1'b1;
          if (m_swcnt[b] == 3)   m_serr[1] = 1'b1;
          m_wcnt[b]  = (m_wcnt[b] + 1) % 1024;
          m_swcnt[b] = (m_swcnt[b] + 1) % 4;
        end else begin
          m_err[0] = 1'b1; m_serr[0] = 1'b1;
        end
      end
      3'd3: begin m_hold = bram0[m_rdc]; m_rdc = (m_rdc + 1) % 1024; end
      3'd4: m_done = 1'b0;
      default: ;
    endcase
    m_ack = ~m_ack;
    send(c, b, d);
    chk("op_krnl_wr", 32'(krnl_wr), 32'(e_kwr));
    if (e_kwr) begin
      chk("op_krnl_row", 32'(krnl_row), e_row);
      chk("op_krnl_data", 32'(krnl_data), 32'(d));
    end
    chk("op_wen", 32'(mem_wen), 32'(e_wen));
    chk("op_s_wen", 32'(s_mem_wen), 32'(e_swen));
    if (e_wen != 0) begin
      chk("op_waddr", 32'(waddr), e_waddr);
      chk("op_wdata", 32'(wdata), 32'(d[12:0]));
      chk("op_s_waddr", 32'(s_waddr), e_swaddr);
    end
    if (c == 3'd3) chk("op_raddr", 32'(raddr), e_raddr);
    chk("op_run", 32'(run), 32'(e_run));
    chk("op_img_len", 32'(img_len), m_len);
    chk("op_ack", 32'(gpio_rd[31]), 32'(m_ack));
    if (c == 3'd3) begin
      @(negedge clk);
      chk("op_dreq_data", 32'(gpio_rd[12:0]), 32'(m_hold));
    end else if (c == 3'd4) begin
      @(negedge clk);
      chk("op_busy", 32'(busy), 32'd1);
      if (drop) begin
        send(3'd2, 2'd0, d);
        m_err[2] = 1'b1; m_serr[2] = 1'b1;
        chk("drop_wen", 32'(mem_wen), 32'd0);
        chk("drop_status", gpio_rd, exp_status(1'b1));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      eop = 1'b1;
      @(negedge clk);
      eop = 1'b0;
      m_done = 1'b1;
      chk("eop_busy", 32'(busy), 32'd0);
    end
    repeat (2) @(negedge clk);
    chk("op_status", gpio_rd, exp_status(1'b0));
    chk("op_s_err", 32'(s_gpio_rd[28:26]), ERR_EN ? 32'(m_serr) : 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required end within time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) bram0[i] = 13'($urandom);
    bram0[0] = 13'h0AB;
    bram0[1] = 13'h1FFF;

    tv[0]  = '{3'd0, 2'd0, 24'h010203, 1'b1, 2'd0, 3'b000, 10'd0, 13'd0, 1'b1};
    tv[1]  = '{3'd0, 2'd0, 24'h040506, 1'b1, 2'd1, 3'b000, 10'd0, 13'd0, 1'b0};
    tv[2]  = '{3'd0, 2'd0, 24'h070809, 1'b1, 2'd2, 3'b000, 10'd0, 13'd0, 1'b1};
    tv[3]  = '{3'd0, 2'd0, 24'h0A0B0C, 1'b1, 2'd0, 3'b000, 10'd0, 13'd0, 1'b0};
    tv[4]  = '{3'd1, 2'd0, 24'h000280, 1'b0, 2'd0, 3'b000, 10'd0, 13'd0, 1'b1};
    tv[5]  = '{3'd2, 2'd0, 24'h000005, 1'b0, 2'd0, 3'b001, 10'd0, 13'd5, 1'b0};
    tv[6]  = '{3'd2, 2'd1, 24'h000006, 1'b0, 2'd0, 3'b010, 10'd0, 13'd6, 1'b1};
    tv[7]  = '{3'd2, 2'd2, 24'h000007, 1'b0, 2'd0, 3'b100, 10'd0, 13'd7, 1'b0};
    tv[8]  = '{3'd2, 2'd0, 24'h000008, 1'b0, 2'd0, 3'b001, 10'd1, 13'd8, 1'b1};
    tv[9]  = '{3'd5, 2'd0, 24'hABCDEF, 1'b0, 2'd0, 3'b000, 10'd0, 13'd0, 1'b0};
    tv[10] = '{3'd2, 2'd3, 24'h000009, 1'b0, 2'd0, 3'b000, 10'd0, 13'd0, 1'b1};
    tv[11] = '{3'd0, 2'd0, 24'h111111, 1'b1, 2'd0, 3'b000, 10'd0, 13'd0, 1'b0};

    apply_reset();
    chk("rst_gpio_rd", gpio_rd, 32'd0);
    chk("rst_krnl_data", 32'(krnl_data), 32'd0);
    chk("rst_krnl_row", 32'(krnl_row), 32'd0);
    chk("rst_krnl_wr", 32'(krnl_wr), 32'd0);
    chk("rst_img_len", 32'(img_len), 32'd0);
    chk("rst_wen", 32'(mem_wen), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_raddr", 32'(raddr), 32'd0);
    chk("rst_run", 32'(run), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 12; i++) begin
      send(tv[i].cmd, tv[i].bank, tv[i].data);
      chk("tv_krnl_wr", 32'(krnl_wr), 32'(tv[i].kwr));
      if (tv[i].kwr) begin
        chk("tv_krnl_row", 32'(krnl_row), 32'(tv[i].row));
        chk("tv_krnl_data", 32'(krnl_data), 32'(tv[i].data));
      end
      chk("tv_wen", 32'(mem_wen), 32'(tv[i].wen));
      if (tv[i].wen != 0) begin
        chk("tv_waddr", 32'(waddr), 32'(tv[i].waddr));
        chk("tv_wdata", 32'(wdata), 32'(tv[i].wdata));
      end
      chk("tv_run", 32'(run), 32'd0);
      chk("tv_ack", 32'(gpio_rd[31]), 32'(tv[i].ack));
      repeat (2) @(negedge clk);
    end
    chk("tv_img_len", 32'(img_len), 32'd640);

    apply_reset();
    do_op(3'd4, 2'd0, 24'h0, 1'b1);
    chk("run_err_drop", 32'(gpio_rd[28]), 32'(ERR_EN));
    chk("run_done", 32'(gpio_rd[30]), 32'd1);
    do_op(3'd3, 2'd0, 24'h0, 1'b0);
    do_op(3'd3, 2'd0, 24'h0, 1'b0);
    chk("dreq_hold", 32'(gpio_rd[12:0]), 32'h1FFF);

    do_op(3'd1, 2'd0, 24'h3, 1'b0);
    for (int i = 0; i < 5; i++) do_op(3'd2, 2'd1, 24'(i + 16), 1'b0);
    chk("wrap_flag_s", 32'(s_gpio_rd[27]), 32'(ERR_EN));
    do_op(3'd2, 2'd3, 24'h55, 1'b0);
    chk("oor_flag", 32'(gpio_rd[26]), 32'(ERR_EN));

    apply_reset();
    for (int k = 0; k < 300; k++)
      do_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 24'($urandom), bit'($urandom_range(0, 1)));

    send(3'd4, 2'd0, 24'h0);
    @(negedge clk);
    chk("t6_busy_before", 32'(busy), 32'd1);
    gpio = mk(3'd2, 1'b1, 2'd0, 24'h7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_run_gpio_rd", gpio_rd, 32'd0);
    chk("t6_run_busy", 32'(busy), 32'd0);
    chk("t6_run_run", 32'(run), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_held_wen", 32'(mem_wen), 32'd0);
      chk("t6_held_gpio_rd", gpio_rd, 32'd0);
    end
    gpio = '0;
    @(negedge clk);
    send(3'd3, 2'd0, 24'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rd_gpio_rd", gpio_rd, 32'd0);
    chk("t6_rd_raddr", 32'(raddr), 32'd0);
    @(negedge clk);
    model_reset();
    do_op(3'd0, 2'd0, 24'h123456, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
